// File: rtl/range_bcd_converter.sv
// range_bcd_converter
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// for the range display path. A conversion starts whenever `bin` differs from
// the last converted value; `bcd` only changes on the `done` cycle.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bin    - binary range value (held between updates)
//   bcd    - packed BCD, digit 0 (units) in [3:0]
//   busy   - conversion in progress
//   done   - one-cycle pulse, bcd/ovf updated this cycle
//   ovf    - last converted value exceeded 10^DIGITS-1 (bcd shows all 9s)
//
// Configuration macro:
//   RANGE_BCD_BLANK_EN - when defined, leading zero digits (except digit 0)
//                        are written as 4'hF so the display shows them blank.
module range_bcd_converter #(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] last_bin;
    logic [BIN_WIDTH-1:0] shreg;
    logic [BCD_W-1:0]     scratch;
    logic                 ovf_acc;
    logic [CNT_W-1:0]     cnt;

    logic [BCD_W-1:0]     adj_c;
    logic [BCD_W-1:0]     next_scratch_c;
    logic                 next_ovf_c;
    logic [BCD_W-1:0]     fmt_c;

    // One double-dabble iteration: correct digits >= 5, then shift in next bit.
    always_comb begin
        adj_c = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj_c[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        next_scratch_c = {adj_c[BCD_W-2:0], shreg[BIN_WIDTH-1]};
        // The bit leaving the top digit means the value no longer fits.
        next_ovf_c     = ovf_acc | adj_c[BCD_W-1];
    end

`ifdef RANGE_BCD_BLANK_EN
    logic lead_c;

    // Leading-zero blanking; digit 0 always stays visible.
    always_comb begin
        fmt_c  = next_scratch_c;
        lead_c = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (lead_c && (next_scratch_c[4*i +: 4] == 4'h0)) begin
                fmt_c[4*i +: 4] = 4'hF;
            end else begin
                lead_c = 1'b0;
            end
        end
    end
`else
    // Leading zeros shown as 4'h0.
    always_comb begin
        fmt_c = next_scratch_c;
    end
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_bin <= '0;
            shreg    <= '0;
            scratch  <= '0;
            ovf_acc  <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bin != last_bin) begin
                        last_bin <= bin;
                        shreg    <= bin;
                        scratch  <= '0;
                        ovf_acc  <= 1'b0;
                        cnt      <= CNT_W'(BIN_WIDTH);
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    scratch <= next_scratch_c;
                    shreg   <= {shreg[BIN_WIDTH-2:0], 1'b0};
                    ovf_acc <= next_ovf_c;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd   <= next_ovf_c ? {DIGITS{4'h9}} : fmt_c;
                        ovf   <= next_ovf_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_bcd_converter.sv
// Bench for range_bcd_converter: table of vectors plus hand-written sequences
// (held input, input change mid-conversion, reset mid-conversion, overflow on
// a 3-digit instance). Expected results are queued when stimulus is driven and
// compared when `done` pulses.
module tb_range_bcd_converter;

`ifdef RANGE_BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, rst3_n;
    logic [15:0] bin, bin3;
    logic [19:0] bcd;
    logic [11:0] bcd3;
    logic        busy, done, ovf;
    logic        busy3, done3, ovf3;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done3_cnt = 0;
    int done_cyc = 0;
    exp_t exp_q[$];
    exp_t exp3_q[$];

    range_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .bin(bin), .bcd(bcd),
        .busy(busy), .done(done), .ovf(ovf)
    );

    range_bcd_converter #(.BIN_WIDTH(16), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .bin(bin3), .bcd(bcd3),
        .busy(busy3), .done(done3), .ovf(ovf3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Decimal reference model (division based).
    function automatic exp_t model(input int v, input int nd);
        exp_t e;
        int   lim = 1;
        int   dg[5];
        bit   lead = 1'b1;
        for (int i = 0; i < nd; i++) lim *= 10;
        e.bcd = '0;
        if (v >= lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < nd; i++) e.bcd[4*i +: 4] = 4'h9;
        end else begin
            e.ovf = 1'b0;
            for (int i = 0; i < nd; i++) begin
                dg[i] = v % 10;
                v = v / 10;
            end
            for (int i = nd - 1; i >= 0; i--) begin
                if (BLANK && lead && i > 0 && dg[i] == 0) e.bcd[4*i +: 4] = 4'hF;
                else begin
                    lead = 1'b0;
                    e.bcd[4*i +: 4] = 4'(dg[i]);
                end
            end
        end
        return e;
    endfunction

    // Scoreboard: compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got bcd=%h, want no done", bcd);
            end else begin
                e = exp_q.pop_front();
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("busy_with_done", 32'(busy), 32'd0);
            end
        end
        if (done3) begin
            done3_cnt++;
            if (exp3_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done3: got bcd3=%h, want no done", bcd3);
            end else begin
                e = exp3_q.pop_front();
                check("bcd3", 32'(bcd3), 32'(e.bcd[11:0]));
                check("ovf3", 32'(ovf3), 32'(e.ovf));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait for done counter (which=0: dut, 1: dut3) to exceed n, bounded.
    task automatic wait_done(input int which, input int n, input string name);
        int k = 0;
        while (((which == 0) ? done_cnt : done3_cnt) <= n && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done in 60 cycles, want done", name);
        end
    endtask

    // Drive one value on the 5-digit instance and check capture and latency.
    task automatic apply(input logic [15:0] v, input exp_t e, input string name);
        int n = done_cnt;
        int dc;
        bin = v;
        exp_q.push_back(e);
        dc = cyc;
        step();
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(0, n, name);
        check({name, "_latency"}, 32'(done_cyc - dc), 32'd17);
        step();
    endtask

    task automatic apply3(input logic [15:0] v, input exp_t e);
        int n = done3_cnt;
        bin3 = v;
        exp3_q.push_back(e);
        wait_done(1, n, "d3");
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[10];
        exp_t  e;
        int    n, dc;
        bit    busy_seen;
        logic [15:0] prev, r;

        vecs[0] = '{16'd123,   BLANK ? 20'hFF123 : 20'h00123, 1'b0};
        vecs[1] = '{16'd65535, 20'h65535,                     1'b0};
        vecs[2] = '{16'd0,     BLANK ? 20'hFFFF0 : 20'h00000, 1'b0};
        vecs[3] = '{16'd9,     BLANK ? 20'hFFFF9 : 20'h00009, 1'b0};
        vecs[4] = '{16'd10000, 20'h10000,                     1'b0};
        vecs[5] = '{16'd4095,  BLANK ? 20'hF4095 : 20'h04095, 1'b0};
        vecs[6] = '{16'd1,     BLANK ? 20'hFFFF1 : 20'h00001, 1'b0};
        vecs[7] = '{16'd50505, 20'h50505,                     1'b0};
        vecs[8] = '{16'd100,   BLANK ? 20'hFF100 : 20'h00100, 1'b0};
        vecs[9] = '{16'd99999 - 16'd34464, 20'h65535 - 20'h0, 1'b0};
        vecs[9] = '{16'd59999, 20'h59999,                     1'b0};

        rst_n = 1'b0;
        rst3_n = 1'b0;
        bin = '0;
        bin3 = '0;
        repeat (3) step();
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd3", 32'(bcd3), 32'd0);
        rst_n = 1'b1;
        rst3_n = 1'b1;
        repeat (5) step();
        check("zero_no_conv_busy", 32'(busy), 32'd0);
        check("zero_no_conv_done", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 10; i++) begin
            e.bcd = vecs[i].bcd;
            e.ovf = vecs[i].ovf;
            apply(vecs[i].bin, e, $sformatf("vec%0d", i));
        end

        prev = vecs[9].bin;
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom_range(0, 65535));
            if (r == prev || r == 16'd400) r = r ^ 16'h0101;
            apply(r, model(int'(r), 5), $sformatf("rnd%0d", i));
            prev = r;
        end

        // Held value: one done only, busy stays low.
        apply(16'd400, model(400, 5), "hold");
        n = done_cnt;
        busy_seen = 1'b0;
        repeat (200) begin
            step();
            if (busy) busy_seen = 1'b1;
        end
        check("hold_done_count", 32'(done_cnt), 32'(n));
        check("hold_busy_seen", 32'(busy_seen), 32'd0);

        // Input change mid-conversion: first result is the captured value.
        n = done_cnt;
        bin = 16'd10;
        exp_q.push_back(model(10, 5));
        exp_q.push_back(model(20, 5));
        dc = cyc;
        step();
        step();
        check("midchg_bcd_held", 32'(bcd), 32'(model(400, 5).bcd));
        bin = 16'd20;
        wait_done(0, n, "midchg1");
        check("midchg1_cycle", 32'(done_cyc - dc), 32'd17);
        wait_done(0, n + 1, "midchg2");
        check("midchg2_cycle", 32'(done_cyc - dc), 32'd34);
        step();

        // Reset mid-conversion.
        n = done_cnt;
        bin = 16'd321;
        repeat (6) step();
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_bcd", 32'(bcd), 32'd0);
        check("rstmid_ovf", 32'(ovf), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check("rstmid_done", 32'(done_cnt), 32'(n));
        exp_q.push_back(model(321, 5));
        check("rstmid_bcd_val", 32'(BLANK ? 20'hFF321 : 20'h00321), 32'(model(321, 5).bcd) ^ 32'(bcd));
        dc = cyc;
        rst_n = 1'b1;
        wait_done(0, n, "rstrel");
        check("rstrel_latency", 32'(done_cyc - dc), 32'd17);
        step();

        // Three-digit instance: overflow and boundary.
        apply3(16'd1000, '{20'h00999, 1'b1});
        apply3(16'd999,  '{20'h00999, 1'b0});
        apply3(16'd5,    '{BLANK ? 20'h00FF5 : 20'h00005, 1'b0});
        apply3(16'd65535, model(65535, 3));
        apply3(16'd0,    '{BLANK ? 20'h00FF0 : 20'h00000, 1'b0});

        repeat (5) step();
        check("queue_empty", 32'(exp_q.size() + exp3_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
